// File: rtl/lmfe_pkg.sv
// Shared constants and types for the lmfe pixel feeder.
// Optional throttling is enabled with macro LMFE_FEEDER_THROTTLE_EN.
package lmfe_pkg;

    localparam int LMFE_DATA_W = 8;
    localparam int LMFE_IMG_W  = 128;
    localparam int LMFE_N_PIX  = 16384;
    localparam int LMFE_ADDR_W = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feeder_state_t;

    // Buffer slots occupied once this edge's push and pop have settled.
    function automatic logic [2:0] slots_used(
        input logic [1:0] cnt,
        input logic       inflight,
        input logic       pop
    );
        return {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/lmfe_skid_fifo2.sv
// Two-entry prefetch buffer; the head register always holds the oldest pixel.
// When empty, head keeps the last popped pixel so the output never glitches.
module lmfe_skid_fifo2
    import lmfe_pkg::*;
#(
    parameter int DATA_W = LMFE_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        cnt
);

    logic [DATA_W-1:0] tail;

    // Shift-style storage: pops move the tail into the head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= din;
                    else             tail <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    if (cnt == 2'd2) head <= tail;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lmfe_feeder.sv
// Streams a frame from a read port into lmfe_top, honouring busy backpressure.
// Define LMFE_FEEDER_THROTTLE_EN to add the gap input for inter-beat spacing.
module lmfe_feeder
    import lmfe_pkg::*;
#(
    parameter int DATA_W = LMFE_DATA_W,
    parameter int N_PIX  = LMFE_N_PIX,
    parameter int ADDR_W = LMFE_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              busy,
`ifdef LMFE_FEEDER_THROTTLE_EN
    input  logic [3:0]        gap,
`endif
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              in_en,
    output logic [DATA_W-1:0] Din,
    output logic              active,
    output logic              done
);

    localparam logic [ADDR_W:0] PIX_END  = (ADDR_W+1)'(N_PIX);
    localparam logic [ADDR_W:0] PIX_LAST = (ADDR_W+1)'(N_PIX - 1);

    feeder_state_t   state;
    logic [ADDR_W:0] rd_cnt;
    logic [ADDR_W:0] beat_cnt;
    logic [1:0]      buf_cnt;
    logic            gap_ok;
    logic            start_ok;
    logic            issue;
    logic            last_beat;

    assign start_ok  = (state == IDLE) && start;
    assign in_en     = (state == STREAM) && (buf_cnt != 2'd0)
                       && !busy && gap_ok;
    assign last_beat = in_en && (beat_cnt == PIX_LAST);

    // A new read needs a free slot after this edge's push and pop.
    always_comb begin
        issue = 1'b0;
        if (start_ok) begin
            issue = 1'b1;
        end else if (state == STREAM) begin
            issue = (rd_cnt < PIX_END)
                    && (slots_used(buf_cnt, mem_rd, in_en) < 3'd2);
        end
    end

    // The read in flight lands in the buffer on the edge that ends it.
    lmfe_skid_fifo2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (mem_rd),
        .pop   (in_en),
        .din   (mem_rdata),
        .head  (Din),
        .cnt   (buf_cnt)
    );

    // Read-side address generation; rd_cnt saturates at N_PIX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            rd_cnt   <= '0;
        end else begin
            mem_rd <= issue;
            if (start_ok) begin
                mem_addr <= '0;
                rd_cnt   <= (ADDR_W+1)'(1);
            end else if (issue) begin
                mem_addr <= rd_cnt[ADDR_W-1:0];
                rd_cnt   <= rd_cnt + (ADDR_W+1)'(1);
            end
        end
    end

    // Frame sequencing: accept start, count beats, pulse done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            active   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= STREAM;
                        active   <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (in_en) beat_cnt <= beat_cnt + (ADDR_W+1)'(1);
                    if (last_beat) begin
                        state  <= DONE;
                        active <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

`ifdef LMFE_FEEDER_THROTTLE_EN
    logic [3:0] gap_cnt;

    assign gap_ok = (gap_cnt == 4'd0);

    // Hold off the next offer for gap cycles after every transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt <= 4'd0;
        end else if (in_en) begin
            gap_cnt <= gap;
        end else if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
        end
    end
`else
    assign gap_ok = 1'b1;
`endif

endmodule

// File: tb/tb_lmfe_feeder.sv
// Directed and randomized checks of lmfe_feeder with a 16-pixel frame.
// Compile with LMFE_FEEDER_THROTTLE_EN to include the gap scenario.
module tb_lmfe_feeder;

    localparam int NP = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
`ifdef LMFE_FEEDER_THROTTLE_EN
    logic [3:0] gap;
`endif
    logic       mem_rd;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       in_en;
    logic [7:0] Din;
    logic       active;
    logic       done;

    logic [7:0] rom [NP];

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int start_edge = 0;
    int gb = 0;
    int ab = 0;
    int db = 0;

    logic [7:0] got   [$];
    int         tedge [$];
    logic [3:0] addrs [$];
    int         dedge [$];
    int         stall_err = 0;
    int         viol = 0;
    logic       pend_v = 1'b0;
    logic [7:0] pend_d = '0;
    logic [7:0] last_x = '0;

    lmfe_feeder #(
        .DATA_W (8),
        .N_PIX  (NP),
        .ADDR_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
`ifdef LMFE_FEEDER_THROTTLE_EN
        .gap       (gap),
`endif
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .in_en     (in_en),
        .Din       (Din),
        .active    (active),
        .done      (done)
    );

    assign mem_rdata = mem_rd ? rom[mem_addr] : 8'hEE;

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Mid-cycle observer: records beats, reads, done pulses, stall behaviour.
    always @(negedge clk) begin
        if (!reset) begin
            pend_v <= 1'b0;
            last_x <= '0;
        end else begin
            if (mem_rd) addrs.push_back(mem_addr);
            if (in_en && pend_v) begin
                if (Din !== pend_d) stall_err <= stall_err + 1;
                pend_v <= 1'b0;
            end
            if (busy && active && Din !== last_x) begin
                if (pend_v && Din !== pend_d) stall_err <= stall_err + 1;
                pend_v <= 1'b1;
                pend_d <= Din;
            end
            if (in_en && busy) viol <= viol + 1;
            if (in_en) begin
                got.push_back(Din);
                tedge.push_back(edge_cnt);
                last_x <= Din;
            end
            if (done) dedge.push_back(edge_cnt);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rom(input bit ident);
        for (int i = 0; i < NP; i++)
            rom[i] = ident ? 8'(i) : 8'($urandom_range(0, 8'hDF));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick();
        tick();
        start_edge = edge_cnt;
        gb = got.size();
        ab = addrs.size();
        db = dedge.size();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (dedge.size() == db && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(dedge.size() > db), 1);
        tick();
        tick();
    endtask

    task automatic frame_check(input string tag);
        check({tag, "_nbeats"}, 32'(got.size() - gb), NP);
        for (int k = 0; k < NP; k++)
            if (gb + k < got.size())
                check({tag, "_data"}, 32'(got[gb+k]), 32'(rom[k]));
        check({tag, "_nreads"}, 32'(addrs.size() - ab), NP);
        for (int k = 0; k < NP; k++)
            if (ab + k < addrs.size())
                check({tag, "_addr"}, 32'(addrs[ab+k]), k);
        check({tag, "_ndone"}, 32'(dedge.size() - db), 1);
        if (dedge.size() > db && got.size() > gb)
            check({tag, "_done_edge"}, 32'(dedge[db] - tedge[$]), 1);
        check({tag, "_active_end"}, 32'(active), 0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        busy  = 1'b0;
`ifdef LMFE_FEEDER_THROTTLE_EN
        gap   = 4'd0;
`endif
        fill_rom(1'b1);
        tick();
        tick();
        check("rst_in_en", 32'(in_en), 0);
        check("rst_active", 32'(active), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_din", 32'(Din), 0);
        reset = 1'b1;
        tick();

        // Full-rate frame with identity ROM.
        kick();
        check("t1_active", 32'(active), 1);
        wait_done("t1");
        frame_check("t1");
        if (got.size() >= gb + NP) begin
            check("t1_first_edge", 32'(tedge[gb] - start_edge), 2);
            check("t1_span", 32'(tedge[gb+NP-1] - tedge[gb]), NP - 1);
        end

        // Alternating busy with random pixels.
        fill_rom(1'b0);
        kick();
        for (int n = 0; n < 200 && dedge.size() == db; n++) begin
            busy = ~busy;
            tick();
        end
        busy = 1'b0;
        wait_done("t2");
        frame_check("t2");

        // Random busy pattern.
        fill_rom(1'b0);
        kick();
        for (int n = 0; n < 300 && dedge.size() == db; n++) begin
            busy = 1'($urandom_range(0, 1));
            tick();
        end
        busy = 1'b0;
        wait_done("t3");
        frame_check("t3");
        check("busy_viol", 32'(viol), 0);
        check("stall_hold", 32'(stall_err), 0);

        // Long stall right after start.
        fill_rom(1'b0);
        busy = 1'b1;
        kick();
        for (int n = 0; n < 50; n++) tick();
        check("t4_reads_stalled", 32'(addrs.size() - ab), 2);
        check("t4_no_beats", 32'(got.size() - gb), 0);
        busy = 1'b0;
        wait_done("t4");
        frame_check("t4");
        if (got.size() >= gb + NP) begin
            check("t4_b2b", 32'(tedge[gb+1] - tedge[gb]), 1);
            check("t4_span", 32'(tedge[gb+NP-1] - tedge[gb]), NP - 1);
        end

        // Extra start pulses mid-frame and during the done cycle.
        fill_rom(1'b0);
        kick();
        for (int n = 0; n < 45; n++) begin
            start = (n == 4) || done;
            tick();
        end
        start = 1'b0;
        frame_check("t5");
        check("t5_idle_reads", 32'(mem_rd), 0);

        // Asynchronous reset after beat 5, then a clean frame.
        fill_rom(1'b0);
        kick();
        for (int n = 0; n < 100 && got.size() < gb + 6; n++) tick();
        check("t6_reached_b5", 32'(got.size() - gb), 6);
        #1;
        reset = 1'b0;
        #1;
        check("t6_rst_in_en", 32'(in_en), 0);
        check("t6_rst_active", 32'(active), 0);
        check("t6_rst_mem_rd", 32'(mem_rd), 0);
        check("t6_rst_din", 32'(Din), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        fill_rom(1'b0);
        kick();
        wait_done("t6b");
        frame_check("t6b");

`ifdef LMFE_FEEDER_THROTTLE_EN
        // Throttled frame: one beat every four cycles.
        fill_rom(1'b0);
        gap = 4'd3;
        kick();
        wait_done("t7");
        frame_check("t7");
        for (int k = 1; k < NP; k++)
            if (gb + k < got.size())
                check("t7_spacing", 32'(tedge[gb+k] - tedge[gb+k-1]), 4);
        gap = 4'd0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lmfe_feeder.md
Name: lmfe_feeder

Overview:
- Synthesizable pixel-stream transmitter that drives the lmfe_top input interface (Din/in_en) and obeys its busy backpressure.
- Reads a raster image of N_PIX pixels from a synchronous ROM/SRAM port and streams it in address order, one pixel per accepted beat.
- Replaces the behavioural stimulus loop in on-chip self-test and in FPGA bring-up, where lmfe_top is fed from block RAM.

Parameters:
DATA_W, 8, pixel width
N_PIX, 16384, pixels per frame (128x128)
ADDR_W, 14, memory address width; 2**ADDR_W >= N_PIX

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
busy  in  1  from lmfe_top; high = no beat may be offered this cycle
mem_rd  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd
in_en  out  1  beat valid to lmfe_top
Din  out  DATA_W  pixel data to lmfe_top
active  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the final beat transfers

Behaviour:
- Reset (reset=0, async): state IDLE, mem_rd=0, mem_addr=0, Din=0, in_en=0, active=0, done=0. Prefetch buffer is emptied. Read and beat counters are set to 0.
- Transfer rule: a beat transfers on a rising edge where in_en=1.
- in_en is combinational: in_en = (state in STREAM) & (buf_cnt!=0) & ~busy.
- Din is always the buffer head. It holds its value while busy=1, and no pixel is ever dropped or duplicated.
- Prefetch buffer: 2-entry FIFO, DATA_W wide. Every read in flight has a reserved slot.
- A read is issued when rd_cnt < N_PIX and (buf_cnt + inflight - pop) < 2.
- mem_addr = rd_cnt, which increments on each issue. rd_cnt never exceeds N_PIX.
- mem_rdata is written into the FIFO on the edge after the read issues. A simultaneous push and pop is allowed.
- Throughput: 1 beat/cycle while busy=0.
- FSM states:
  IDLE: start=1 moves to STREAM and sets active=1.
  STREAM: issues reads and offers beats. When the final beat transfers (beat_cnt==N_PIX-1 with in_en=1), moves to DONE.
  DONE: done=1 for one cycle, active=0, then moves to IDLE.
- Latency: start is sampled at edge 0. mem_rd for address 0 is high in cycle 0-1, and data is captured at edge 1. in_en is first high in cycle 1-2 if busy=0.
- start while not IDLE is ignored, including in the DONE cycle.
- busy rising in the cycle a beat is offered: in_en drops in the same cycle with no transfer, and Din holds.
- busy held high indefinitely: the FIFO fills to 2, reads stop, and no timeout applies.
- Reset mid-frame: aborts immediately to reset values. A late mem_rdata is discarded.
- Counters are ADDR_W+1 bits wide so that N_PIX=2**ADDR_W does not wrap.

Optional Feature:
- Macro: LMFE_FEEDER_THROTTLE_EN.
- When defined: adds input gap[3:0]. After each transferred beat, in_en is forced low for gap cycles. Prefetch continues during the gap. gap=0 is identical to the feature being absent.
- When undefined: the port is absent and there is no throttling logic.

Decomposition:
- Package lmfe_pkg holds:
  - LMFE_DATA_W=8, LMFE_IMG_W=128, LMFE_N_PIX=16384, LMFE_ADDR_W=14
  - enum feeder_state_t {IDLE, STREAM, DONE}
- One sub-module: lmfe_skid_fifo2, the 2-entry FIFO with push, pop, head and cnt.

Test Plan:
- N_PIX=16, ROM[i]=i, busy=0: start at edge 0. Beats 0x00..0x0F on 16 consecutive edges, first transfer at edge 2. done pulses one cycle after beat 0x0F, active falls, and mem_rd issues exactly 16 reads.
- busy toggling 1,0,1,0...: all 16 values arrive in order with no duplicates. in_en=0 whenever busy=1, and Din stable across stalled cycles.
- busy=1 for 50 cycles right after start: exactly 2 reads issued, no in_en. On release, beats 0x00 and 0x01 go on back-to-back edges and streaming continues at full rate.
- start pulsed again mid-frame and during DONE: ignored, exactly 16 beats and a single done pulse.
- reset low after beat 5 transfers: in_en, active and mem_rd go to 0 asynchronously. A new start then streams again from 0x00.
- LMFE_FEEDER_THROTTLE_EN with gap=3, busy=0: transfers are exactly 4 cycles apart, all 16 values arrive, and done follows the last beat.
